// File: rtl/seg7_refresh_ctrl.sv
// Refresh-frame sequencer for the 7-segment serializer: picks one of eight
// 32-bit channels, latches it with its masks, pulses Start and tracks the frame handshake.
module seg7_refresh_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned FLASH_DIV   = 25000000,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   ch_sel,
  input  logic [255:0] ch_data,
  input  logic [7:0]   point_in,
  input  logic [7:0]   les_in,
  input  logic         freeze,
  input  logic         seg_pen,
  output logic [31:0]  Hexs,
  output logic [7:0]   point,
  output logic [7:0]   LES,
  output logic         Start,
  output logic         flash,
  output logic [7:0]   frame_cnt,
  output logic         overrun,
  output logic         timeout
);

  localparam int unsigned REF_W   = $clog2(REFRESH_DIV);
  localparam int unsigned FLASH_W = $clog2(FLASH_DIV);
  localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [REF_W-1:0]   REF_MAX   = REF_W'(REFRESH_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_MAX = FLASH_W'(FLASH_DIV - 1);
  localparam logic [TO_W-1:0]    TO_MAX    = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t             state, state_d;
  logic [REF_W-1:0]   ref_cnt;
  logic [FLASH_W-1:0] flash_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               pending;
  logic               tick;

  logic               load;
  logic               frame_done;
  logic               to_hit;
  logic               to_run;

  assign tick  = (ref_cnt == REF_MAX);
  assign Start = (state == START);

  // Free-running refresh and blink dividers; neither depends on the FSM.
  // NOTE: every register is updated with <= so all flops sample the same
  // pre-edge values; a blocking = here would chain them within one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt   <= '0;
      flash_cnt <= '0;
      flash     <= 1'b0;
    end else begin
      ref_cnt <= tick ? '0 : ref_cnt + REF_W'(1);
      if (flash_cnt == FLASH_MAX) begin
        flash_cnt <= '0;
        flash     <= ~flash;
      end else begin
        flash_cnt <= flash_cnt + FLASH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    state_d    = state;
    load       = 1'b0;
    frame_done = 1'b0;
    to_hit     = 1'b0;
    to_run     = 1'b0;
    case (state)
      IDLE: begin
        if (tick || pending) state_d = LATCH;
      end
      LATCH: begin
        load    = !freeze;
        state_d = START;
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!seg_pen) begin
          state_d = WAIT_DONE;
        end else if (to_cnt == TO_MAX) begin
          to_hit  = 1'b1;
          state_d = IDLE;
        end else begin
          to_run = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (seg_pen) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A tick that finds the FSM busy is remembered once; IDLE always consumes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt    <= '0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      to_cnt <= to_run ? to_cnt + TO_W'(1) : '0;
      if (state == IDLE)  pending <= 1'b0;
      else if (tick)      pending <= 1'b1;
      if (tick && state != IDLE) overrun <= 1'b1;
      if (to_hit)                timeout <= 1'b1;
      if (frame_done)            frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Hexs  <= '0;
      point <= '0;
      LES   <= '0;
    end else if (load) begin
      Hexs  <= ch_data[{ch_sel, 5'd0} +: 32];
      point <= point_in;
      LES   <= les_in;
    end
  end

endmodule

// File: tb/tb_seg7_refresh_ctrl.sv
// Directed bench for seg7_refresh_ctrl with a small serializer model driving seg_pen.
// Cycle k is the clock period following the k-th rising edge after reset release.
module tb_seg7_refresh_ctrl;

  localparam int REFRESH_DIV = 8;
  localparam int FLASH_DIV   = 4;
  localparam int TIMEOUT     = 16;

  logic         clk;
  logic         rst;
  logic [2:0]   ch_sel;
  logic [255:0] ch_data;
  logic [7:0]   point_in;
  logic [7:0]   les_in;
  logic         freeze;
  logic         seg_pen;
  logic [31:0]  Hexs;
  logic [7:0]   point;
  logic [7:0]   LES;
  logic         Start;
  logic         flash;
  logic [7:0]   frame_cnt;
  logic         overrun;
  logic         timeout;

  int  total = 0;
  int  bad   = 0;
  time rel_t = 0;

  // Serializer model knobs: idle cycles after Start, then busy cycles.
  int ser_delay  = 3;
  int ser_len    = 20;
  bit ser_enable = 1'b1;

  seg7_refresh_ctrl #(
    .REFRESH_DIV(REFRESH_DIV),
    .FLASH_DIV  (FLASH_DIV),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_sel   (ch_sel),
    .ch_data  (ch_data),
    .point_in (point_in),
    .les_in   (les_in),
    .freeze   (freeze),
    .seg_pen  (seg_pen),
    .Hexs     (Hexs),
    .point    (point),
    .LES      (LES),
    .Start    (Start),
    .flash    (flash),
    .frame_cnt(frame_cnt),
    .overrun  (overrun),
    .timeout  (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Serializer: after seeing Start, waits ser_delay cycles, pulls seg_pen low
  // for ser_len cycles, then returns to idle; a reset aborts it.
  initial begin
    seg_pen = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && Start === 1'b1 && ser_enable) begin
        for (int i = 0; i < ser_delay && rst; i++) @(negedge clk);
        if (rst) seg_pen = 1'b0;
        for (int j = 0; j < ser_len && rst; j++) @(negedge clk);
        seg_pen = 1'b1;
      end
    end
  end

  function automatic int cyc_now();
    return int'(($time - rel_t) / 10);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    rel_t = $time;
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (Start === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (Hexs !== 32'h0 || point !== 8'h0 || LES !== 8'h0) begin
      bad++;
      $display("FAIL reset_data: Hexs=%h point=%h LES=%h expected all 0", Hexs, point, LES);
    end
    total++;
    if ({Start, flash, frame_cnt, overrun, timeout} !== 12'h0) begin
      bad++;
      $display("FAIL reset_ctrl: Start=%b flash=%b frame_cnt=%0d overrun=%b timeout=%b expected all 0",
               Start, flash, frame_cnt, overrun, timeout);
    end
  endtask

  task automatic test_frame_timing();
    bit seen;
    ser_enable = 1'b1; ser_delay = 3; ser_len = 20;
    do_reset();
    wait_start(40, seen);
    total++;
    if (!seen || cyc_now() != 9) begin
      bad++; $display("FAIL t1_first_start: seen=%0b cycle=%0d expected cycle 9", seen, cyc_now());
    end
    total++;
    if (frame_cnt !== 8'd0) begin bad++; $display("FAIL t1_cnt0: frame_cnt=%0d expected 0", frame_cnt); end
    @(negedge clk);
    total++;
    if (Start !== 1'b0) begin bad++; $display("FAIL t1_width1: Start=%b expected 0", Start); end
    wait_start(60, seen);
    total++;
    if (!seen || cyc_now() != 35) begin
      bad++; $display("FAIL t1_second_start: seen=%0b cycle=%0d expected cycle 35", seen, cyc_now());
    end
    total++;
    if (frame_cnt !== 8'd1) begin bad++; $display("FAIL t1_cnt1: frame_cnt=%0d expected 1", frame_cnt); end
    @(negedge clk);
    total++;
    if (Start !== 1'b0) begin bad++; $display("FAIL t1_width2: Start=%b expected 0", Start); end
    wait_start(60, seen);
    total++;
    if (!seen || cyc_now() != 61) begin
      bad++; $display("FAIL t1_third_start: seen=%0b cycle=%0d expected cycle 61", seen, cyc_now());
    end
    total++;
    if (frame_cnt !== 8'd2) begin bad++; $display("FAIL t1_cnt2: frame_cnt=%0d expected 2", frame_cnt); end
    total++;
    if (overrun !== 1'b1 || timeout !== 1'b0) begin
      bad++; $display("FAIL t1_flags: overrun=%b timeout=%b expected 1 0", overrun, timeout);
    end
  endtask

  task automatic test_latch_freeze();
    bit seen;
    ch_sel = 3'd5; ch_data[160 +: 32] = 32'hDEADBEEF; point_in = 8'h0F; les_in = 8'hA5; freeze = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);
    total++;
    if (Hexs !== 32'h0 || point !== 8'h0) begin
      bad++; $display("FAIL t2_before_latch: Hexs=%h point=%h expected 0 0", Hexs, point);
    end
    wait_start(40, seen);
    total++;
    if (!seen || Hexs !== 32'hDEADBEEF || point !== 8'h0F || LES !== 8'hA5) begin
      bad++; $display("FAIL t2_latch: seen=%0b Hexs=%h point=%h LES=%h expected DEADBEEF 0F A5", seen, Hexs, point, LES);
    end
    freeze = 1'b1; ch_data[160 +: 32] = 32'h12345678; point_in = 8'hF0; les_in = 8'h3C;
    wait_start(60, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL t2_freeze_start: Start never pulsed while frozen"); end
    total++;
    if (Hexs !== 32'hDEADBEEF || point !== 8'h0F || LES !== 8'hA5) begin
      bad++; $display("FAIL t2_freeze_hold: Hexs=%h point=%h LES=%h expected DEADBEEF 0F A5", Hexs, point, LES);
    end
    freeze = 1'b0; ch_sel = 3'd2; ch_data[64 +: 32] = 32'hCAFEF00D;
    wait_start(60, seen);
    total++;
    if (!seen || Hexs !== 32'hCAFEF00D || point !== 8'hF0 || LES !== 8'h3C) begin
      bad++; $display("FAIL t2_ch2: seen=%0b Hexs=%h point=%h LES=%h expected CAFEF00D F0 3C", seen, Hexs, point, LES);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    bit found;
    ser_enable = 1'b0;
    do_reset();
    wait_start(40, seen);
    total++;
    if (!seen || cyc_now() != 9) begin
      bad++; $display("FAIL t3_start: seen=%0b cycle=%0d expected cycle 9", seen, cyc_now());
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) found = 1'b1;
    end
    total++;
    if (!found || cyc_now() != 26) begin
      bad++; $display("FAIL t3_timeout_time: found=%0b cycle=%0d expected cycle 26", found, cyc_now());
    end
    total++;
    if (frame_cnt !== 8'd0) begin bad++; $display("FAIL t3_cnt: frame_cnt=%0d expected 0", frame_cnt); end
    wait_start(40, seen);
    total++;
    if (!seen || cyc_now() != 28) begin
      bad++; $display("FAIL t3_back_to_idle: seen=%0b cycle=%0d expected cycle 28", seen, cyc_now());
    end
    total++;
    if (overrun !== 1'b1 || frame_cnt !== 8'd0) begin
      bad++; $display("FAIL t3_flags: overrun=%b frame_cnt=%0d expected 1 0", overrun, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    bit found;
    ser_enable = 1'b1; ser_delay = 3; ser_len = 30;
    do_reset();
    wait_start(40, seen);
    total++;
    if (!seen || cyc_now() != 9 || overrun !== 1'b0) begin
      bad++; $display("FAIL t4_first: seen=%0b cycle=%0d overrun=%b expected cycle 9 overrun 0", seen, cyc_now(), overrun);
    end
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (frame_cnt === 8'd1) found = 1'b1;
    end
    total++;
    if (!found || cyc_now() != 43) begin
      bad++; $display("FAIL t4_frame1_done: found=%0b cycle=%0d expected cycle 43", found, cyc_now());
    end
    ser_delay = 1; ser_len = 2;
    wait_start(20, seen);
    total++;
    if (!seen || cyc_now() != 45 || overrun !== 1'b1) begin
      bad++; $display("FAIL t4_pending: seen=%0b cycle=%0d overrun=%b expected cycle 45 overrun 1", seen, cyc_now(), overrun);
    end
    wait_start(20, seen);
    total++;
    if (!seen || cyc_now() != 51) begin
      bad++; $display("FAIL t4_start51: seen=%0b cycle=%0d expected cycle 51", seen, cyc_now());
    end
    wait_start(20, seen);
    total++;
    if (!seen || cyc_now() != 57) begin
      bad++; $display("FAIL t4_start57: seen=%0b cycle=%0d expected cycle 57", seen, cyc_now());
    end
    wait_start(20, seen);
    total++;
    if (!seen || cyc_now() != 65 || frame_cnt !== 8'd4) begin
      bad++; $display("FAIL t4_one_deep: seen=%0b cycle=%0d frame_cnt=%0d expected cycle 65 count 4", seen, cyc_now(), frame_cnt);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    ser_enable = 1'b1; ser_delay = 3; ser_len = 20;
    do_reset();
    wait_start(40, seen);
    wait_start(60, seen);
    total++;
    if (!seen || cyc_now() != 35) begin
      bad++; $display("FAIL t5_setup: seen=%0b cycle=%0d expected cycle 35", seen, cyc_now());
    end
    repeat (10) @(negedge clk);
    total++;
    if (frame_cnt !== 8'd1 || overrun !== 1'b1 || Hexs !== 32'hCAFEF00D) begin
      bad++; $display("FAIL t5_pre_reset: frame_cnt=%0d overrun=%b Hexs=%h expected 1 1 CAFEF00D", frame_cnt, overrun, Hexs);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({Hexs, point, LES, frame_cnt} !== 56'h0) begin
      bad++; $display("FAIL t5_async_data: Hexs=%h point=%h LES=%h frame_cnt=%0d expected all 0", Hexs, point, LES, frame_cnt);
    end
    total++;
    if ({Start, flash, overrun, timeout} !== 4'h0) begin
      bad++; $display("FAIL t5_async_ctrl: Start=%b flash=%b overrun=%b timeout=%b expected all 0", Start, flash, overrun, timeout);
    end
    ser_delay = 1; ser_len = 2;
    repeat (2) @(negedge clk);
    rst = 1'b1; rel_t = $time;
    wait_start(40, seen);
    total++;
    if (!seen || cyc_now() != REFRESH_DIV + 1 || frame_cnt !== 8'd0) begin
      bad++; $display("FAIL t5_restart: seen=%0b cycle=%0d frame_cnt=%0d expected cycle 9 count 0", seen, cyc_now(), frame_cnt);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (Start !== 1'b0) begin bad++; $display("FAIL t5_start_drop: Start=%b expected 0", Start); end
    repeat (2) @(negedge clk);
    rst = 1'b1; rel_t = $time;
    for (int n = 1; n <= 256; n++) begin
      wait_start(40, seen);
      if (!seen) begin
        total++; bad++;
        $display("FAIL t5_wrap_start: frame %0d never started", n);
        break;
      end
      if (n == 128 || n == 256) begin
        total++;
        if (frame_cnt !== 8'(n - 1)) begin
          bad++; $display("FAIL t5_wrap_count: frame %0d frame_cnt=%0d expected %0d", n, frame_cnt, n - 1);
        end
      end
    end
    repeat (5) @(negedge clk);
    total++;
    if (frame_cnt !== 8'd0) begin bad++; $display("FAIL t5_wrap: frame_cnt=%0d expected 0", frame_cnt); end
  endtask

  task automatic test_flash();
    logic [15:0] flash_exp;
    flash_exp = 16'h7878;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++;
      if (flash !== flash_exp[i]) begin
        bad++; $display("FAIL t6_flash: cycle=%0d flash=%b expected %b", i + 1, flash, flash_exp[i]);
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    ch_sel   = 3'd0;
    point_in = 8'h00;
    les_in   = 8'h00;
    freeze   = 1'b0;
    for (int i = 0; i < 8; i++) ch_data[32*i +: 32] = 32'h1111_1111 * (i + 1);
    test_reset();
    test_frame_timing();
    test_latch_freeze();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_flash();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
